// File: rtl/step_pulse_gen.sv
// step_pulse_gen: debounced push-button to one-cycle step pulses, with
// hold-to-repeat while the button stays down and auto-scroll while it is up.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_IDLE      | button released; auto-scroll timer may run
// S_WAIT_HOLD | button held; hold timer running (saturates if no repeat)
// S_REPEAT    | button held past hold time; repeat timer emits steps
module step_pulse_gen #(
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int AUTO_CYCLES   = 25000000,
    parameter int CNT_W         = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic rpt_en,
    input  logic auto_en,
    output logic step,
    output logic btn_db,
    output logic repeating
);

    localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] AUTO_TC = CNT_W'(AUTO_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HOLD = 2'd1,
        S_REPEAT    = 2'd2
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_deb_cnt;
    logic             r_btn_db;
    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] r_auto_cnt;
    logic             r_step;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] w_rpt_nxt;
    logic [CNT_W-1:0] w_auto_nxt;
    logic             w_step_nxt;
    logic             w_db_rise;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the level only flips after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_deb_cnt <= '0;
            r_btn_db  <= 1'b0;
        end else if (r_sync2 != r_btn_db) begin
            if (r_deb_cnt == DEB_TC) begin
                r_btn_db  <= ~r_btn_db;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + ONE;
            end
        end else begin
            r_deb_cnt <= '0;
        end
    end

    // A press becomes visible to the FSM on the next edge; used to merge an
    // auto tick landing just before it into the press step.
    assign w_db_rise = (r_sync2 != r_btn_db) && (r_deb_cnt == DEB_TC) && !r_btn_db;

    // State, timers and the registered step pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_rpt_cnt  <= '0;
            r_auto_cnt <= '0;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rpt_cnt  <= w_rpt_nxt;
            r_auto_cnt <= w_auto_nxt;
            r_step     <= w_step_nxt & ~r_step;
        end
    end

    // Next-state, timer and step decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_rpt_nxt   = r_rpt_cnt;
        w_auto_nxt  = '0;
        w_step_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_hold_nxt = '0;
                w_rpt_nxt  = '0;
                if (r_btn_db) begin
                    // Press step; any coincident auto tick is absorbed here.
                    w_state_nxt = S_WAIT_HOLD;
                    w_step_nxt  = 1'b1;
                end else if (auto_en) begin
                    if (r_auto_cnt == AUTO_TC) begin
                        w_step_nxt = !w_db_rise;
                    end else begin
                        w_auto_nxt = r_auto_cnt + ONE;
                    end
                end
            end
            S_WAIT_HOLD: begin
                if (!r_btn_db) begin
                    w_state_nxt = S_IDLE;
                end else if (r_hold_cnt == HOLD_TC) begin
                    if (rpt_en) begin
                        w_state_nxt = S_REPEAT;
                        w_rpt_nxt   = '0;
                        w_step_nxt  = 1'b1;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + ONE;
                end
            end
            S_REPEAT: begin
                if (!r_btn_db) begin
                    w_state_nxt = S_IDLE;
                end else if (!rpt_en) begin
                    w_state_nxt = S_WAIT_HOLD;
                    w_hold_nxt  = HOLD_TC;
                end else if (r_rpt_cnt == REP_TC) begin
                    w_rpt_nxt  = '0;
                    w_step_nxt = 1'b1;
                end else begin
                    w_rpt_nxt = r_rpt_cnt + ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign step      = r_step;
    assign btn_db    = r_btn_db;
    assign repeating = (r_state == S_REPEAT);

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with small timer parameters.
module tb_step_pulse_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 5;
    localparam int AUTO = 8;
    localparam int CW   = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic btn_raw = 1'b0;
    logic rpt_en  = 1'b0;
    logic auto_en = 1'b0;
    logic step;
    logic btn_db;
    logic repeating;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int exp_q[$];
    logic prev_step = 1'b0;

    // debounce reference
    logic m_s1, m_s2, m_db;
    int   m_cnt;

    step_pulse_gen #(
        .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
        .AUTO_CYCLES(AUTO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .rpt_en(rpt_en),
        .auto_en(auto_en), .step(step), .btn_db(btn_db), .repeating(repeating)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_db <= 1'b0; m_cnt <= 0;
        end else begin
            m_s1 <= btn_raw;
            m_s2 <= m_s1;
            if (m_s2 != m_db) begin
                if (m_cnt == DEB - 1) begin
                    m_db  <= ~m_db;
                    m_cnt <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    // monitor: pop the expected cycle whenever a step appears
    always @(negedge clk) begin
        if (rst_n) begin
            if (step) begin
                chk("step_not_back_to_back", int'(prev_step), 0);
                if (exp_q.size() == 0) chk("step_unexpected_cycle", cyc, -1);
                else chk("step_cycle", cyc, exp_q.pop_front());
            end
            chk("btn_db_debounce", int'(btn_db), int'(m_db));
        end
        prev_step = step;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // press at t0 (negedge), release at t_rel: press step at +7, repeat steps
    // from +17 every 5 while the debounced level is still high (<= t_rel+6)
    task automatic push_press(input int t0, input int t_rel, input bit rpt);
        exp_q.push_back(t0 + 7);
        if (rpt) begin
            for (int t = t0 + 17; t <= t_rel + 6; t += 5) exp_q.push_back(t);
        end
    endtask

    initial begin
        int t, h0, n0, a0, r, q0, q1;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_step", int'(step), 0);
        chk("reset_btn_db", int'(btn_db), 0);
        chk("reset_repeating", int'(repeating), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(cyc + 3);

        // bounce, then steady high; rpt_en=0
        t = cyc;
        exp_q.push_back(t + 27);
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        chk("bounce_db_low", int'(btn_db), 0);
        btn_raw = 1'b1;
        wait_cyc(t + 40);
        btn_raw = 1'b0;
        wait_cyc(t + 52);

        // hold with repeat
        rpt_en = 1'b1;
        h0 = cyc;
        push_press(h0, h0 + 40, 1'b1);
        btn_raw = 1'b1;
        wait_cyc(h0 + 10);
        chk("hold_db_high", int'(btn_db), 1);
        wait_cyc(h0 + 16);
        chk("hold_not_repeating", int'(repeating), 0);
        wait_cyc(h0 + 18);
        chk("hold_repeating", int'(repeating), 1);
        wait_cyc(h0 + 40);
        btn_raw = 1'b0;
        wait_cyc(h0 + 48);
        chk("release_repeating", int'(repeating), 0);
        chk("release_db_low", int'(btn_db), 0);
        wait_cyc(h0 + 55);

        // no repeat
        rpt_en = 1'b0;
        n0 = cyc;
        push_press(n0, n0 + 40, 1'b0);
        btn_raw = 1'b1;
        wait_cyc(n0 + 25);
        chk("norpt_repeating", int'(repeating), 0);
        wait_cyc(n0 + 40);
        btn_raw = 1'b0;
        wait_cyc(n0 + 55);

        // auto-scroll with a press mid-period
        a0 = cyc;
        r  = a0 + 60;
        auto_en = 1'b1;
        for (int k = 1; k <= 6; k++) exp_q.push_back(a0 + 8 * k);
        exp_q.push_back(a0 + 51);
        exp_q.push_back(r + 15);
        exp_q.push_back(r + 23);
        wait_cyc(a0 + 44);
        btn_raw = 1'b1;
        wait_cyc(r);
        btn_raw = 1'b0;
        wait_cyc(r + 25);
        auto_en = 1'b0;
        wait_cyc(r + 35);

        // reset while repeating
        rpt_en = 1'b1;
        q0 = cyc;
        exp_q.push_back(q0 + 7);
        exp_q.push_back(q0 + 17);
        exp_q.push_back(q0 + 22);
        btn_raw = 1'b1;
        wait_cyc(q0 + 22);
        chk("pre_reset_repeating", int'(repeating), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_step", int'(step), 0);
        chk("async_reset_btn_db", int'(btn_db), 0);
        chk("async_reset_repeating", int'(repeating), 0);
        wait_cyc(q0 + 24);
        rst_n = 1'b1;
        q1 = cyc;
        exp_q.push_back(q1 + 7);
        exp_q.push_back(q1 + 17);
        exp_q.push_back(q1 + 22);
        wait_cyc(q1 + 20);
        chk("post_reset_repeating", int'(repeating), 1);
        wait_cyc(q1 + 24);
        rpt_en = 1'b0;
        wait_cyc(q1 + 26);
        chk("rpt_off_repeating", int'(repeating), 0);
        wait_cyc(q1 + 30);
        btn_raw = 1'b0;
        wait_cyc(q1 + 45);

        chk("steps_all_seen", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 50000, consecutive clk cycles a changed input must persist before the debounced level changes.
REQ-002 Parameter HOLD_CYCLES, default 25000000, cycles the button must be held after the press step before auto-repeat begins.
REQ-003 Parameter REPEAT_CYCLES, default 5000000, period in cycles of repeat steps while held.
REQ-004 Parameter AUTO_CYCLES, default 25000000, period in cycles of auto-scroll steps while idle.
REQ-005 Parameter CNT_W, default 25, width of all internal timers; every cycle parameter SHALL be in the range 2..2^CNT_W.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_raw  input  1  raw push-button, asynchronous to clk, may bounce.
REQ-009 rpt_en  input  1  enables hold-to-repeat.
REQ-010 auto_en  input  1  enables auto-scroll while button released.
REQ-011 step  output  1  one-cycle advance pulse, registered; feeds the downstream display index stage.
REQ-012 btn_db  output  1  debounced button level, registered.
REQ-013 repeating  output  1  high while in REPEAT state.

Function
REQ-014 btn_raw SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-015 Debounce: counter increments each cycle sync != btn_db; clears to 0 whenever sync == btn_db; when counter reaches DEB_CYCLES-1 with sync still differing, btn_db toggles at the next edge and the counter clears.
REQ-016 States: IDLE (btn_db=0), WAIT_HOLD (btn_db=1, hold timer running), REPEAT (btn_db=1, repeat timer running).
REQ-017 IDLE -> WAIT_HOLD on btn_db 0->1; step asserted in the cycle after btn_db rises; hold timer cleared.
REQ-018 WAIT_HOLD -> REPEAT when hold timer reaches HOLD_CYCLES-1 and rpt_en=1; step asserted once on that transition; repeat timer cleared.
REQ-019 WAIT_HOLD with rpt_en=0: hold timer saturates at HOLD_CYCLES-1 and no further steps are emitted.
REQ-020 REPEAT: step asserted each time the repeat timer reaches REPEAT_CYCLES-1, then the timer wraps to 0; rpt_en falling returns to WAIT_HOLD with the hold timer saturated (no steps).
REQ-021 Any state -> IDLE on btn_db 1->0; release SHALL never produce a step.
REQ-022 Auto-scroll: in IDLE with auto_en=1, auto timer counts; step asserted when it reaches AUTO_CYCLES-1, then it wraps to 0; timer held at 0 when auto_en=0 or state != IDLE.
REQ-023 Simultaneous auto tick and press step in one cycle SHALL yield a single one-cycle step; the auto timer clears.
REQ-024 step SHALL never be high in two consecutive cycles, and never more than one pulse per event.
REQ-025 Total press latency: step high during the cycle following edge DEB_CYCLES+3 after btn_raw first sampled high (steady input).
REQ-026 Bounces shorter than DEB_CYCLES cycles SHALL cause no change in btn_db and no step.

Reset
REQ-027 rst_n low SHALL immediately force step=0, btn_db=0, repeating=0, state IDLE, synchronizer flops and all timers 0, regardless of clk.
REQ-028 After rst_n rises with btn_raw held high, the block SHALL treat it as a new press (one step after REQ-025 latency).

Verification (DEB=4, HOLD=10, REPEAT=5, AUTO=8, CNT_W=8)
REQ-029 Bounce: btn_raw toggles every 2 cycles for 20 cycles then stays high 20 cycles, rpt_en=0 -> btn_db rises once, exactly one step.
REQ-030 Hold: clean press held 40 cycles, rpt_en=1 -> step at press, second step 10 cycles later, then every 5 cycles; repeating=1 after second step; release -> no step, repeating=0.
REQ-031 No repeat: same press, rpt_en=0 -> exactly one step; repeating stays 0.
REQ-032 Auto: auto_en=1, btn_raw=0 for 40 cycles -> steps every 8 cycles (5 pulses); press mid-period -> one press step, auto timer restarts from 0 only after btn_db falls.
REQ-033 Reset mid-REPEAT: rst_n low asynchronously -> all outputs 0 within the same cycle; rst_n high with btn_raw held -> one step 7 cycles later, then repeat sequence per REQ-030.
REQ-034 Checker on all runs: step never high two consecutive cycles; btn_db changes only after 4 consecutive differing sync samples.
